// File: rtl/cnn_fmap_pkg.sv
// Shared definitions for the flat feature-map bus blocks (serializer, deserializer).
package cnn_fmap_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Index widths never collapse to zero bits, so degenerate dimensions still get a 1-bit port.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fmap_stream_serializer_if.sv
// Element stream leaving the serializer: data plus its (channel, row, col) position.
interface fmap_stream_serializer_if #(
  parameter int BITWIDTH    = 8,
  parameter int DATAWIDTH   = 28,
  parameter int DATAHEIGHT  = 28,
  parameter int DATACHANNEL = 3
);

  localparam int CW = cnn_fmap_pkg::clog2_min1(DATAWIDTH);
  localparam int RW = cnn_fmap_pkg::clog2_min1(DATAHEIGHT);
  localparam int KW = cnn_fmap_pkg::clog2_min1(DATACHANNEL);

  logic [BITWIDTH-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic [KW-1:0]       out_channel;
  logic [RW-1:0]       out_row;
  logic [CW-1:0]       out_col;
  logic                out_last;

  modport master (
    output out_data, out_valid, out_channel, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_channel, out_row, out_col, out_last,
    output out_ready
  );

endinterface

// File: rtl/fmap_index_counter.sv
// Nested (ch, row, col) wrap counter walking a feature map in channel-major order.
module fmap_index_counter
  import cnn_fmap_pkg::*;
#(
  parameter int W = 28,
  parameter int H = 28,
  parameter int C = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      inc,
  output logic [clog2_min1(W)-1:0]  col,
  output logic [clog2_min1(H)-1:0]  row,
  output logic [clog2_min1(C)-1:0]  ch,
  output logic                      last
);

  localparam int CW = clog2_min1(W);
  localparam int RW = clog2_min1(H);
  localparam int KW = clog2_min1(C);

  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);
  localparam logic [KW-1:0] CH_MAX  = KW'(C - 1);

  // A dimension of size 1 has MAX == 0, so it wraps on every step and stays at 0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else if (inc) begin
      if (col == COL_MAX) begin
        col <= '0;
        if (row == ROW_MAX) begin
          row <= '0;
          if (ch == CH_MAX) ch <= '0;
          else              ch <= ch + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (col == COL_MAX) && (row == ROW_MAX) && (ch == CH_MAX);

endmodule

// File: rtl/fmap_stream_serializer.sv
// Captures a whole flat feature map in one cycle and streams it out one element per
// accepted valid/ready beat in (channel, row, col) order.
module fmap_stream_serializer
  import cnn_fmap_pkg::*;
#(
  parameter int BITWIDTH    = 8,
  parameter int DATAWIDTH   = 28,
  parameter int DATAHEIGHT  = 28,
  parameter int DATACHANNEL = 3
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  load,
  output logic                                                  load_ready,
  input  logic [BITWIDTH*DATAWIDTH*DATAHEIGHT*DATACHANNEL-1:0]  data,
  fmap_stream_serializer_if.master                              out_if
);

  localparam int NUM  = DATAWIDTH * DATAHEIGHT * DATACHANNEL;
  localparam int CW   = clog2_min1(DATAWIDTH);
  localparam int RW   = clog2_min1(DATAHEIGHT);
  localparam int KW   = clog2_min1(DATACHANNEL);
  localparam int OFFW = clog2_min1(BITWIDTH * NUM);

  state_t                   state;
  state_t                   state_next;
  logic [BITWIDTH*NUM-1:0]  map_q;
  logic [CW-1:0]            col;
  logic [RW-1:0]            row;
  logic [KW-1:0]            ch;
  logic                     idx_last;
  logic                     valid;
  logic                     xfer;
  logic                     clear;
  logic [OFFW-1:0]          bit_off;

  assign valid      = (state == STREAM);
  assign load_ready = (state == IDLE);
  assign xfer       = valid && out_if.out_ready;
  // Holding the counter cleared through IDLE guarantees element 0 is first after any load.
  assign clear      = (state == IDLE) || (xfer && idx_last);

  fmap_index_counter #(
    .W (DATAWIDTH),
    .H (DATAHEIGHT),
    .C (DATACHANNEL)
  ) u_index (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (xfer),
    .col   (col),
    .row   (row),
    .ch    (ch),
    .last  (idx_last)
  );

  // The map register is deliberately left out of reset; it is only read while streaming.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && load) begin
      map_q <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load)              state_next = STREAM;
      STREAM:  if (xfer && idx_last)  state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  always_comb begin
    bit_off = OFFW'(((int'(ch) * DATAHEIGHT + int'(row)) * DATAWIDTH + int'(col)) * BITWIDTH);
  end

  assign out_if.out_data    = map_q[bit_off +: BITWIDTH];
  assign out_if.out_valid   = valid;
  assign out_if.out_channel = ch;
  assign out_if.out_row     = row;
  assign out_if.out_col     = col;
  assign out_if.out_last    = idx_last && valid;

endmodule

// File: tb/tb_fmap_stream_serializer.sv
// Self-checking bench: a 2x2x1 instance for directed timing cases and a default 28x28x3
// instance for a randomised full-map run, both checked against a scoreboard queue.
module tb_fmap_stream_serializer;

  localparam int BW   = 8;
  localparam int BNUM = 28 * 28 * 3;

  typedef struct {
    logic [7:0] d;
    int         ch;
    int         row;
    int         col;
    logic       last;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              s_load;
  logic              s_load_ready;
  logic [31:0]       s_data;
  logic              b_load;
  logic              b_load_ready;
  logic [BW*BNUM-1:0] b_data;

  int   checks = 0;
  int   errors = 0;
  exp_t s_q[$];
  exp_t b_q[$];
  int   win;

  fmap_stream_serializer_if #(.BITWIDTH(8), .DATAWIDTH(2), .DATAHEIGHT(2), .DATACHANNEL(1)) s_if ();
  fmap_stream_serializer_if #(.BITWIDTH(8), .DATAWIDTH(28), .DATAHEIGHT(28), .DATACHANNEL(3)) b_if ();

  fmap_stream_serializer #(.BITWIDTH(8), .DATAWIDTH(2), .DATAHEIGHT(2), .DATACHANNEL(1)) dut_small (
    .clk        (clk),
    .rst        (rst),
    .load       (s_load),
    .load_ready (s_load_ready),
    .data       (s_data),
    .out_if     (s_if)
  );

  fmap_stream_serializer #(.BITWIDTH(8), .DATAWIDTH(28), .DATAHEIGHT(28), .DATACHANNEL(3)) dut_big (
    .clk        (clk),
    .rst        (rst),
    .load       (b_load),
    .load_ready (b_load_ready),
    .data       (b_data),
    .out_if     (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t make_exp(input int e, input int w, input int h, input int c,
                                    input logic [7:0] d);
    exp_t x;
    x.d    = d;
    x.ch   = e / (w * h);
    x.row  = (e / w) % h;
    x.col  = e % w;
    x.last = (e == w * h * c - 1);
    return x;
  endfunction

  task automatic push_small(input logic [31:0] m);
    for (int e = 0; e < 4; e++) s_q.push_back(make_exp(e, 2, 2, 1, m[e*8 +: 8]));
  endtask

  task automatic check_small_idle(input string tag);
    check({tag, "_valid"}, 32'(s_if.out_valid), 32'd0);
    check({tag, "_load_ready"}, 32'(s_load_ready), 32'd1);
  endtask

  // Walks the small stream until its out_last beat transfers; checks every valid cycle
  // against the scoreboard head so stalls must hold and transfers must advance.
  task automatic drain_small(input logic [31:0] pat, input int pat_len, input logic hold_load,
                             input logic load_at_last, output int windows);
    bit   done;
    exp_t e;
    done    = 1'b0;
    windows = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      s_if.out_ready = (pat_len == 0) ? 1'b1 : pat[cyc % pat_len];
      s_load         = hold_load;
      windows++;
      if (s_if.out_valid) begin
        checks++;
        assert (s_q.size() != 0)
        else begin
          errors++;
          $error("FAIL small_extra_beat: observed data %0h with empty scoreboard", s_if.out_data);
        end
        if (s_q.size() != 0) begin
          e = s_q[0];
          check("small_data", 32'(s_if.out_data), 32'(e.d));
          check("small_row", 32'(s_if.out_row), e.row);
          check("small_col", 32'(s_if.out_col), e.col);
          check("small_ch", 32'(s_if.out_channel), e.ch);
          check("small_last", 32'(s_if.out_last), 32'(e.last));
          check("small_load_ready_busy", 32'(s_load_ready), 32'd0);
          if (s_if.out_ready) begin
            void'(s_q.pop_front());
            if (e.last) begin
              s_load = load_at_last;
              done   = 1'b1;
            end
          end
        end
      end
      tick();
    end
    checks++;
    assert (done)
    else begin
      errors++;
      $error("FAIL small_timeout: observed no last beat within 200 cycles, required one");
    end
  endtask

  task automatic drain_big(output int beats);
    bit   done;
    exp_t e;
    done  = 1'b0;
    beats = 0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      b_if.out_ready = ($urandom_range(0, 3) != 0);
      if (b_if.out_valid && b_if.out_ready) begin
        checks++;
        assert (b_q.size() != 0)
        else begin
          errors++;
          $error("FAIL big_extra_beat: observed data %0h with empty scoreboard", b_if.out_data);
        end
        if (b_q.size() != 0) begin
          e = b_q.pop_front();
          beats++;
          check("big_data", 32'(b_if.out_data), 32'(e.d));
          check("big_ch", 32'(b_if.out_channel), e.ch);
          check("big_row", 32'(b_if.out_row), e.row);
          check("big_col", 32'(b_if.out_col), e.col);
          check("big_last", 32'(b_if.out_last), 32'(e.last));
          if (e.last) done = 1'b1;
        end
      end
      tick();
    end
    checks++;
    assert (done)
    else begin
      errors++;
      $error("FAIL big_timeout: observed %0d beats, required last beat of %0d", beats, BNUM);
    end
  endtask

  initial begin
    rst            = 1'b1;
    s_load         = 1'b0;
    b_load         = 1'b0;
    s_data         = '0;
    b_data         = '0;
    s_if.out_ready = 1'b0;
    b_if.out_ready = 1'b0;
    tick();
    tick();

    // Reset state of both instances
    check_small_idle("rst_small");
    check("rst_small_idx", {s_if.out_channel, s_if.out_row, s_if.out_col, s_if.out_last}, 32'd0);
    check("rst_big_valid", 32'(b_if.out_valid), 32'd0);
    check("rst_big_load_ready", 32'(b_load_ready), 32'd1);
    check("rst_big_idx", 32'({b_if.out_channel, b_if.out_row, b_if.out_col, b_if.out_last}), 32'd0);
    rst = 1'b0;
    tick();

    // Basic 2x2 stream with out_ready held high
    s_data = 32'h04030201;
    push_small(s_data);
    s_load = 1'b1;
    tick();
    s_load = 1'b0;
    check("basic_valid_after_load", 32'(s_if.out_valid), 32'd1);
    drain_small(32'h0, 0, 1'b0, 1'b0, win);
    check("basic_beat_cycles", win, 32'd4);
    check_small_idle("basic_end");

    // Backpressure with out_ready pattern 1,0,0,1,0,1,1
    push_small(s_data);
    s_load = 1'b1;
    tick();
    s_load = 1'b0;
    drain_small(32'b1101001, 7, 1'b0, 1'b0, win);
    check_small_idle("bp_end");

    // Load pulsed with a different map while streaming must be ignored
    s_data = 32'hA4A3A2A1;
    push_small(s_data);
    s_load = 1'b1;
    tick();
    s_data = 32'h5D5C5B5A;
    drain_small(32'b101, 3, 1'b1, 1'b0, win);
    check_small_idle("busy_end");
    tick();
    check("busy_stays_idle", 32'(s_if.out_valid), 32'd0);

    // Reset in the middle of a stream
    s_data = 32'hC4C3C2C1;
    s_load = 1'b1;
    tick();
    s_load         = 1'b0;
    s_if.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_small_idle("midrst");
    check("midrst_idx", {s_if.out_channel, s_if.out_row, s_if.out_col, s_if.out_last}, 32'd0);
    s_q.delete();

    // Back-to-back maps with load held high
    s_data = 32'h14131211;
    push_small(s_data);
    push_small(32'h24232221);
    s_load = 1'b1;
    tick();
    s_data = 32'h24232221;
    drain_small(32'h0, 0, 1'b1, 1'b1, win);
    check_small_idle("b2b_bubble");
    tick();
    check("b2b_second_valid", 32'(s_if.out_valid), 32'd1);
    drain_small(32'h0, 0, 1'b0, 1'b0, win);
    check("b2b_second_cycles", win, 32'd4);
    check("b2b_sb_empty", s_q.size(), 32'd0);

    // Full default-size map with random backpressure
    for (int e = 0; e < BNUM; e++) begin
      b_data[e*8 +: 8] = 8'($urandom);
      b_q.push_back(make_exp(e, 28, 28, 3, b_data[e*8 +: 8]));
    end
    b_load = 1'b1;
    tick();
    b_load = 1'b0;
    drain_big(win);
    check("big_beats", win, BNUM);
    check("big_end_valid", 32'(b_if.out_valid), 32'd0);
    check("big_end_load_ready", 32'(b_load_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
